// File: rtl/sram_wait.sv
// sram_wait: single-port word SRAM behind a fixed-latency req/ready/ack handshake.
//
// A request is taken when req and ready are both high at a rising edge. The block then
// stays busy for LATENCY cycles. On the last busy edge, a write updates the enabled byte
// lanes or a read loads rd. The next cycle emits a one-cycle ack, and the block returns to idle.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   reset  - asynchronous active-low reset (clears FSM, counter, rd; not the array)
//   req    - request valid
//   we     - 1 = write, 0 = read
//   addr   - word address
//   wd     - write data
//   be     - byte-lane write enables, be[i] covers wd[8i+7:8i]
//   ready  - high only while idle
//   ack    - one-cycle completion pulse
//   rd     - registered read data, held until the next read completes
module sram_wait #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned LATENCY = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned NB     = WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wd,
  input  logic [NB-1:0]     be,
  output logic              ready,
  output logic              ack,
  output logic [WIDTH-1:0]  rd
);

  // Elaboration-time parameter sanity checks.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("sram_wait: WIDTH must be a multiple of 8 and at least 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sram_wait: DEPTH must be a power of two and at least 2");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("sram_wait: LATENCY must be in 1..15");
  end

  // Counter is loaded with LATENCY-1 on acceptance and counts down to zero; the edge that
  // sees zero is the LATENCY-th edge after acceptance, so it never wraps.
  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              complete;

  // Request captured at acceptance; later input changes cannot disturb it.
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wd_q;
  logic [NB-1:0]     be_q;

  logic [WIDTH-1:0]  rd_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      be_q   <= '0;
    end else if (accept) begin
      we_q   <= we;
      addr_q <= addr;
      wd_q   <= wd;
      be_q   <= be;
    end
  end

  // Read data register: only a completing read updates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else if (complete && !we_q) begin
      rd_q <= mem[addr_q];
    end
  end

  // Storage array: no reset, no initialisation. complete is forced low while reset is
  // asserted (state is idle), so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (complete && we_q) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= wd_q[8*i +: 8];
        end
      end
    end
  end

  assign ready = (state_q == StIdle);
  assign ack   = (state_q == StDone);
  assign rd    = rd_q;

endmodule
